// File: rtl/alu.sv
// 32-bit MIPS-style ALU: combinational result path plus HI/LO registers
// written by multiply and divide.
module alu (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] in_s1,
   input  logic [31:0] in_s2,
   input  logic [5:0]  alu_opcode,
   output logic [31:0] res,
   output logic        zero
);

   localparam logic [5:0] OP_SLL   = 6'h00;
   localparam logic [5:0] OP_SRL   = 6'h02;
   localparam logic [5:0] OP_SRA   = 6'h03;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_MFHI  = 6'h10;
   localparam logic [5:0] OP_MFLO  = 6'h12;
   localparam logic [5:0] OP_MULT  = 6'h18;
   localparam logic [5:0] OP_MULTU = 6'h19;
   localparam logic [5:0] OP_DIV   = 6'h1A;
   localparam logic [5:0] OP_DIVU  = 6'h1B;
   localparam logic [5:0] OP_ADD   = 6'h20;
   localparam logic [5:0] OP_ADDU  = 6'h21;
   localparam logic [5:0] OP_SUB   = 6'h22;
   localparam logic [5:0] OP_SUBU  = 6'h23;
   localparam logic [5:0] OP_AND   = 6'h24;
   localparam logic [5:0] OP_OR    = 6'h25;
   localparam logic [5:0] OP_XOR   = 6'h26;
   localparam logic [5:0] OP_NOR   = 6'h27;
   localparam logic [5:0] OP_SLT   = 6'h2A;
   localparam logic [5:0] OP_SLTU  = 6'h2B;

   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] hi_next;
   logic [31:0] lo_next;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic signed [31:0] divisor_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] divisor_u;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;

   assign prod_s = $signed({{32{in_s1[31]}}, in_s1}) * $signed({{32{in_s2[31]}}, in_s2});
   assign prod_u = {32'h0, in_s1} * {32'h0, in_s2};

   // The divider always sees a safe divisor; the special cases are muxed in below.
   assign div_zero  = (in_s2 == 32'h0);
   assign div_ovf   = (in_s1 == 32'h8000_0000) && (in_s2 == 32'hFFFF_FFFF);
   assign divisor_s = (div_zero || div_ovf) ? 32'sd1 : $signed(in_s2);
   assign quot_s    = $signed(in_s1) / divisor_s;
   assign rem_s     = $signed(in_s1) % divisor_s;
   assign divisor_u = div_zero ? 32'h1 : in_s2;
   assign quot_u    = in_s1 / divisor_u;
   assign rem_u     = in_s1 % divisor_u;

   always_comb begin
      hi_next = hi;
      lo_next = lo;
      case (alu_opcode)
         OP_MULT: begin
            hi_next = prod_s[63:32];
            lo_next = prod_s[31:0];
         end
         OP_MULTU: begin
            hi_next = prod_u[63:32];
            lo_next = prod_u[31:0];
         end
         OP_DIV: begin
            if (div_zero) begin
               hi_next = in_s1;
               lo_next = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               hi_next = 32'h0;
               lo_next = 32'h8000_0000;
            end else begin
               hi_next = rem_s;
               lo_next = quot_s;
            end
         end
         OP_DIVU: begin
            if (div_zero) begin
               hi_next = in_s1;
               lo_next = 32'hFFFF_FFFF;
            end else begin
               hi_next = rem_u;
               lo_next = quot_u;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end else begin
         hi <= hi_next;
         lo <= lo_next;
      end
   end

   always_comb begin
      res = 32'h0;
      case (alu_opcode)
         OP_ADD, OP_ADDU: res = in_s1 + in_s2;
         OP_SUB, OP_SUBU: res = in_s1 - in_s2;
         OP_AND:  res = in_s1 & in_s2;
         OP_OR:   res = in_s1 | in_s2;
         OP_XOR:  res = in_s1 ^ in_s2;
         OP_NOR:  res = ~(in_s1 | in_s2);
         OP_SLT:  res = {31'h0, ($signed(in_s1) < $signed(in_s2))};
         OP_SLTU: res = {31'h0, (in_s1 < in_s2)};
         OP_SLL:  res = in_s1 << in_s2[4:0];
         OP_SRL:  res = in_s1 >> in_s2[4:0];
         OP_SRA:  res = $unsigned($signed(in_s1) >>> in_s2[4:0]);
         OP_LUI:  res = {in_s2[15:0], 16'h0};
         OP_MFHI: res = hi;
         OP_MFLO: res = lo;
         default: res = 32'h0;
      endcase
   end

   assign zero = (res == 32'h0);

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a table of combinational vectors followed by
// hand-written HI/LO sequences covering latency, reset priority and divide corners.
module tb_alu;

   logic        clock;
   logic        reset_n;
   logic [31:0] in_s1;
   logic [31:0] in_s2;
   logic [5:0]  alu_opcode;
   logic [31:0] res;
   logic        zero;

   int n_vec = 0;
   int n_bad = 0;

   alu dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_s1      (in_s1),
      .in_s2      (in_s2),
      .alu_opcode (alu_opcode),
      .res        (res),
      .zero       (zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.r = r; v.z = (r == 32'h0); v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, got, exp);
      end
   endtask

   // Drive on the falling edge; outputs are combinational so sample 1ns later.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      alu_opcode = op;
      in_s1 = a;
      in_s2 = b;
      #1;
   endtask

   task automatic op_then_read(input string name, input logic [5:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(op, a, b);
      issue(6'h10, 32'h0, 32'h0);
      check32({name, " hi"}, res, exp_hi);
      issue(6'h12, 32'h0, 32'h0);
      check32({name, " lo"}, res, exp_lo);
   endtask

   initial begin
      reset_n    = 1'b0;
      in_s1      = 32'h0;
      in_s2      = 32'h0;
      alu_opcode = 6'h3F;

      add_vec(6'h20, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, "add wrap");
      add_vec(6'h21, 32'hFFFF_FFFF, 32'h2,         32'h1,         "addu wrap");
      add_vec(6'h22, 32'h5,         32'h5,         32'h0,         "sub equal");
      add_vec(6'h23, 32'h0,         32'h1,         32'hFFFF_FFFF, "subu borrow");
      add_vec(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
      add_vec(6'h25, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, "or");
      add_vec(6'h26, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0, "xor");
      add_vec(6'h27, 32'h0,         32'h0,         32'hFFFF_FFFF, "nor");
      add_vec(6'h2A, 32'hFFFF_FFFF, 32'h1,         32'h1,         "slt neg");
      add_vec(6'h2A, 32'h1,         32'hFFFF_FFFF, 32'h0,         "slt pos");
      add_vec(6'h2B, 32'hFFFF_FFFF, 32'h1,         32'h0,         "sltu");
      add_vec(6'h2B, 32'h1,         32'hFFFF_FFFF, 32'h1,         "sltu true");
      add_vec(6'h00, 32'h1,         32'h1F,        32'h8000_0000, "sll 31");
      add_vec(6'h00, 32'h1,         32'h21,        32'h2,         "sll b40");
      add_vec(6'h03, 32'h8000_0000, 32'h4,         32'hF800_0000, "sra neg");
      add_vec(6'h03, 32'h4000_0000, 32'h4,         32'h0400_0000, "sra pos");
      add_vec(6'h02, 32'h8000_0000, 32'h4,         32'h0800_0000, "srl");
      add_vec(6'h0F, 32'hFFFF_FFFF, 32'hABCD_1234, 32'h1234_0000, "lui");
      add_vec(6'h18, 32'h3,         32'h3,         32'h0,         "mult res");
      add_vec(6'h1B, 32'h9,         32'h2,         32'h0,         "divu res");
      add_vec(6'h3F, 32'h1234_5678, 32'h1,         32'h0,         "op 3f");
      add_vec(6'h01, 32'h1234_5678, 32'h1,         32'h0,         "op 01");

      // Reset edge with opcodes that do not touch HI/LO
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      issue(6'h10, 32'h0, 32'h0);
      check32("reset hi", res, 32'h0);
      check1 ("reset hi zero", zero, 1'b1);
      issue(6'h12, 32'h0, 32'h0);
      check32("reset lo", res, 32'h0);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         check32(vecs[i].name, res, vecs[i].r);
         check1({vecs[i].name, " zero"}, zero, vecs[i].z);
      end

      op_then_read("mult",  6'h18, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      op_then_read("multu", 6'h19, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA);
      op_then_read("div neg",  6'h1A, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op_then_read("div negb", 6'h1A, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
      op_then_read("divu",     6'h1B, 32'h64,        32'h7,         32'h2,         32'hE);
      op_then_read("divu by0", 6'h1B, 32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF);
      op_then_read("div by0",  6'h1A, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
      op_then_read("div ovf",  6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

      // HI/LO hold across non-writing opcodes
      op_then_read("load", 6'h19, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0);
      issue(6'h20, 32'h1, 32'h2);
      issue(6'h1F, 32'h5, 32'h7);
      issue(6'h10, 32'h0, 32'h0);
      check32("hold hi", res, 32'h3);
      issue(6'h12, 32'h0, 32'h0);
      check32("hold lo", res, 32'h0);
      check1 ("hold lo zero", zero, 1'b1);

      // Read timing: old LO visible until the MULT edge, new LO right after
      op_then_read("pre", 6'h19, 32'h5, 32'h7, 32'h0, 32'h23);
      issue(6'h18, 32'h2, 32'h2);
      check32("mult cycle res", res, 32'h0);
      issue(6'h12, 32'h0, 32'h0);
      check32("mflo after mult", res, 32'h4);
      issue(6'h10, 32'h0, 32'h0);
      check32("mfhi after mult", res, 32'h0);

      // Back-to-back writes each overwrite
      issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(6'h1B, 32'h11, 32'h4);
      issue(6'h12, 32'h0, 32'h0);
      check32("b2b lo", res, 32'h4);
      issue(6'h10, 32'h0, 32'h0);
      check32("b2b hi", res, 32'h1);

      // Reset wins over a simultaneous MULT
      op_then_read("preload", 6'h19, 32'hFFFF_FFFE, 32'h3, 32'h2, 32'hFFFF_FFFA);
      @(negedge clock);
      reset_n    = 1'b0;
      alu_opcode = 6'h18;
      in_s1      = 32'h3;
      in_s2      = 32'h3;
      @(negedge clock);
      reset_n = 1'b1;
      alu_opcode = 6'h10;
      #1;
      check32("rst prio hi", res, 32'h0);
      issue(6'h12, 32'h0, 32'h0);
      check32("rst prio lo", res, 32'h0);

      // Outputs keep following inputs while reset is held
      @(negedge clock);
      reset_n = 1'b0;
      alu_opcode = 6'h20;
      in_s1 = 32'h10;
      in_s2 = 32'h20;
      #1;
      check32("add in reset", res, 32'h30);
      @(negedge clock);
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clock  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 in_s1  input  32  operand A: rs register value.
REQ-005 in_s2  input  32  operand B: rt register value or immediate, selected upstream.
REQ-006 alu_opcode  input  6  operation select, using the MIPS funct encoding of REQ-009.
REQ-007 res  output  32  combinational result.
REQ-008 zero  output  1  combinational; 1 exactly when res == 0.

Function
REQ-009 Opcode map SHALL be (hex):
- 20 ADD, 21 ADDU: A+B, modulo 2^32.
- 22 SUB, 23 SUBU: A-B, modulo 2^32.
- 24 AND, 25 OR, 26 XOR, 27 NOR: bitwise.
- 2A SLT: signed A<B gives 1, else 0.
- 2B SLTU: unsigned A<B gives 1, else 0.
- 00 SLL, 02 SRL, 03 SRA: A shifted by B[4:0]; SRA sign-fills.
- 0F LUI: res = {B[15:0], 16'h0}.
- 10 MFHI: res = HI; 12 MFLO: res = LO.
- 18 MULT, 19 MULTU, 1A DIV, 1B DIVU: res = 0.
REQ-010 ADD and SUB SHALL wrap silently; there is no overflow trap and no overflow flag.
REQ-011 Any unlisted opcode SHALL give res = 0, and therefore zero = 1.
REQ-012 res and zero SHALL be purely combinational from in_s1, in_s2, alu_opcode, HI and LO, with no clock latency.
REQ-013 The block SHALL hold two internal 32-bit registers, HI and LO; they are the only state.
REQ-014 MULT SHALL write the signed 64-bit product A*B into {HI,LO} at the next rising edge; latency is 1 cycle.
REQ-015 MULTU SHALL do the same as MULT, treating A and B as unsigned.
REQ-016 DIV SHALL write LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend, at the next rising edge.
REQ-017 DIVU SHALL write the unsigned quotient to LO and the unsigned remainder to HI, at the next rising edge.
REQ-018 Divide by zero (DIV or DIVU, B = 0) SHALL write LO = 32'hFFFFFFFF and HI = A.
REQ-019 Signed overflow (DIV with A = 32'h80000000 and B = 32'hFFFFFFFF) SHALL write LO = 32'h80000000 and HI = 0.
REQ-020 HI and LO SHALL hold their values on every cycle whose opcode is not MULT, MULTU, DIV or DIVU.
REQ-021 MFHI or MFLO issued in the cycle right after a MULT or DIV SHALL return the newly written value.
REQ-022 MFHI or MFLO issued in the same cycle as a write SHALL return the pre-write value.
REQ-023 Back-to-back MULT/DIV operations SHALL each overwrite HI and LO; there are no busy or stall outputs.

Reset
REQ-024 When reset_n = 0 at a rising edge, HI and LO SHALL become 0.
REQ-025 Reset SHALL take priority over a simultaneous MULT, MULTU, DIV or DIVU write.
REQ-026 res and zero SHALL have no reset value of their own.
REQ-027 During reset, res and zero SHALL keep following their inputs; MFHI and MFLO therefore return 0 after the reset edge.
REQ-028 HI and LO SHALL be undefined until the first reset edge; the bench SHALL apply reset before any MFHI or MFLO check.

Verification
REQ-029 Arithmetic and zero flag:
- ADD 7FFFFFFF + 1 -> res 80000000, zero 0.
- SUB 5 - 5 -> res 0, zero 1.
- NOR 0, 0 -> FFFFFFFF.
REQ-030 Compare, shift and LUI:
- SLT FFFFFFFF, 1 -> 1; SLTU FFFFFFFF, 1 -> 0.
- SRA 80000000 by 4 -> F8000000; SRL 80000000 by 4 -> 08000000.
- LUI B = 1234 -> 12340000.
REQ-031 Multiply, A = FFFFFFFE, B = 3:
- MULT, then MFHI -> FFFFFFFF and MFLO -> FFFFFFFA.
- MULTU -> HI 00000002, LO FFFFFFFA.
REQ-032 Divide:
- DIV FFFFFFF9 / 2 -> LO FFFFFFFD, HI FFFFFFFF.
- DIVU 7 / 0 -> LO FFFFFFFF, HI 7.
- DIV 80000000 / FFFFFFFF -> LO 80000000, HI 0.
REQ-033 Reset behaviour:
- Load HI/LO nonzero, then drive reset_n = 0 together with MULT 3*3 for one edge -> MFHI = MFLO = 0.
- Unlisted opcode 3F -> res 0, zero 1.
REQ-034 Read timing:
- MULT 2*2 followed by MFLO in the next cycle -> 4.
- MFLO in the same cycle as that MULT -> previous LO.
